fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and load-use hazard unit for the pipelined MIPS core.

---
 rtl/fwd_hazard_unit.sv | 191 +++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the pipelined MIPS core. It sits
// between decode and the EX operand muxes.
//
// Each decode-stage source operand is compared against every in-flight
// producer (k=0 EX, k=1 MEM, k=2 WB, ...). The bypass select for each operand
// is registered at the clock edge that moves the instruction into EX, so the
// EX muxes see a stable select for the whole EX cycle.
//
// A load in EX whose result is needed by the instruction in ID cannot be
// forwarded in time. The unit then stalls PC and IF/ID for LOAD_LAT cycles
// and drives zero selects for the bubbles that enter EX.
//
// Parameters
//   REG_AW   register address width; address 0 is the hard-wired zero
//   NUM_SRC  operands checked per instruction
//   NUM_FWD  producer stages checked, youngest (EX) first
//   LOAD_LAT load-use stall length in cycles; needs LOAD_LAT >= 1 and
//            NUM_FWD >= LOAD_LAT+1 so the load is still forwardable afterwards
//   CNT_W    width of the saturating stall performance counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        branch/exception flush of ID and EX
//   id_src_addr  operand i address at [i*REG_AW +: REG_AW]
//   id_src_used  operand i is actually read by the ID instruction
//   prod_rd      destination register of producer k at [k*REG_AW +: REG_AW]
//   prod_wr      producer k writes the register file
//   prod_load    producer k is a load (only the EX bit can cause a stall)
//   fwd_sel      registered select per operand: 0 = regfile, k+1 = producer k
//   stall        freeze PC and IF/ID, bubble into EX
//   stall_cnt    saturating count of stalled cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter  int REG_AW   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int NUM_FWD  = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_FWD*REG_AW-1:0] prod_rd,
    input  logic [NUM_FWD-1:0]        prod_wr,
    input  logic [NUM_FWD-1:0]        prod_load,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    // The countdown only has to hold LOAD_LAT-1; keep at least one bit so
    // the LOAD_LAT==1 configuration still elaborates cleanly.
    localparam int DCNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [DCNT_W-1:0]          dcnt;
    logic [DCNT_W-1:0]          dcnt_next;
    logic [NUM_SRC*NUM_FWD-1:0] match;
    logic [NUM_SRC*SEL_W-1:0]   sel_next;
    logic                       load_use;

    // Only the EX load bit matters for stalling; loads further down the
    // pipe already have their data and are forwarded like any producer.
    generate
        if (NUM_FWD > 1) begin : g_unused_load
            logic unused_load_bits;
            assign unused_load_bits = ^prod_load[NUM_FWD-1:1];
        end
    endgenerate

    // Operand/producer match matrix. Register 0 never matches because it
    // reads as zero regardless of what any producer claims to write.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                match[i*NUM_FWD + k] = id_src_used[i]
                                     & prod_wr[k]
                                     & (prod_rd[k*REG_AW +: REG_AW] == id_src_addr[i*REG_AW +: REG_AW])
                                     & (id_src_addr[i*REG_AW +: REG_AW] != '0);
            end
        end
    end

    // Per-operand priority select. Walking from the oldest producer to the
    // youngest lets the youngest match overwrite, so the most recent value
    // of the register is the one forwarded.
    always_comb begin
        sel_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (match[i*NUM_FWD + k]) begin
                    sel_next[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Load-use hazard: any used operand matching a load currently in EX.
    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            load_use = load_use | match[i*NUM_FWD];
        end
        load_use = load_use & prod_load[0];
    end

    // Stall FSM, next-state and outputs.
    // The first stall cycle is the IDLE cycle in which the hazard is seen;
    // STALL then covers the remaining LOAD_LAT-1 cycles. dcnt is loaded with
    // the number of STALL cycles and the FSM leaves STALL on the cycle whose
    // decrement brings it to zero, after which IDLE re-evaluates the hazard
    // with the load one stage further on. Flush kills the stalled
    // instruction, so it overrides both a fresh hazard and an active STALL.
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = load_use;
                if (load_use && (LOAD_LAT > 1)) begin
                    state_next = STALL;
                    dcnt_next  = DCNT_W'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                stall     = 1'b1;
                dcnt_next = dcnt - DCNT_W'(1);
                if (dcnt <= DCNT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                dcnt_next  = '0;
            end
        endcase
        if (flush) begin
            stall      = 1'b0;
            state_next = IDLE;
            dcnt_next  = '0;
        end
    end

    // Stall FSM state and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
        end
    end

    // Bypass select register. A stall or flush puts a bubble into EX, and a
    // bubble must never forward, so its selects are forced to the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel <= '0;
        end else if (stall || flush) begin
            fwd_sel <= '0;
        end else begin
            fwd_sel <= sel_next;
        end
    end

    // Stall performance counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit with LOAD_LAT=2. Two instances share
// every input: the main one with a 16-bit stall counter and a second one with
// a 4-bit counter so saturation is reached in a handful of stall cycles.
// Expected values are pushed into a scoreboard queue tagged with the cycle in
// which they must be visible; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int NUM_FWD  = 3;
    localparam int LOAD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [9:0]  id_src_addr = '0;
    logic [1:0]  id_src_used = '0;
    logic [14:0] prod_rd = '0;
    logic [2:0]  prod_wr = '0;
    logic [2:0]  prod_load = '0;

    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;
    logic [3:0]  fwd_sel_s;
    logic        stall_s;
    logic [3:0]  stall_cnt_s;

    fwd_hazard_unit #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
        .LOAD_LAT(LOAD_LAT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .prod_rd(prod_rd), .prod_wr(prod_wr), .prod_load(prod_load),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
        .LOAD_LAT(LOAD_LAT), .CNT_W(4)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .prod_rd(prod_rd), .prod_wr(prod_wr), .prod_load(prod_load),
        .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
    );

    // Free-running clock and cycle index used to tag expectations.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          tag;
        bit          chk_sel;
        logic [3:0]  sel;
        bit          chk_stall;
        logic        stall;
        bit          chk_cnt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Compares both instances against one expectation entry.
    task automatic checkOutput(input exp_t e);
        logic [3:0] cnt_s_exp;
        cnt_s_exp = (e.cnt > 16'd15) ? 4'hF : e.cnt[3:0];
        if (e.chk_sel) begin
            tests_run++;
            if (fwd_sel !== e.sel) begin
                tests_failed++;
                $display("[TB] FAIL %s fwd_sel: got %h expected %h (cycle %0d)", e.name, fwd_sel, e.sel, e.tag);
            end
            tests_run++;
            if (fwd_sel_s !== e.sel) begin
                tests_failed++;
                $display("[TB] FAIL %s fwd_sel_small: got %h expected %h (cycle %0d)", e.name, fwd_sel_s, e.sel, e.tag);
            end
        end
        if (e.chk_stall) begin
            tests_run++;
            if (stall !== e.stall) begin
                tests_failed++;
                $display("[TB] FAIL %s stall: got %b expected %b (cycle %0d)", e.name, stall, e.stall, e.tag);
            end
            tests_run++;
            if (stall_s !== e.stall) begin
                tests_failed++;
                $display("[TB] FAIL %s stall_small: got %b expected %b (cycle %0d)", e.name, stall_s, e.stall, e.tag);
            end
        end
        if (e.chk_cnt) begin
            tests_run++;
            if (stall_cnt !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL %s stall_cnt: got %h expected %h (cycle %0d)", e.name, stall_cnt, e.cnt, e.tag);
            end
            tests_run++;
            if (stall_cnt_s !== cnt_s_exp) begin
                tests_failed++;
                $display("[TB] FAIL %s stall_cnt_small: got %h expected %h (cycle %0d)", e.name, stall_cnt_s, cnt_s_exp, e.tag);
            end
        end
    endtask

    // Monitor: everything due in the current cycle is checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.tag < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s late: checked at cycle %0d, required at %0d", mon_e.name, cyc, mon_e.tag);
            end else begin
                checkOutput(mon_e);
            end
        end
    end

    // Drives one ID/producer snapshot for one cycle. The stall and counter
    // are due in that same cycle; the registered select is due one cycle on.
    task automatic applyStimulus(input string name, input logic [9:0] src, input logic [1:0] used,
                                 input logic [14:0] rd, input logic [2:0] wr, input logic [2:0] ld,
                                 input logic fl, input logic exp_stall, input logic [3:0] exp_sel,
                                 input logic [15:0] exp_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        id_src_addr = src;
        id_src_used = used;
        prod_rd     = rd;
        prod_wr     = wr;
        prod_load   = ld;
        flush       = fl;
        e.name      = name;
        e.tag       = cyc;
        e.chk_sel   = 1'b0;
        e.sel       = '0;
        e.chk_stall = 1'b1;
        e.stall     = exp_stall;
        e.chk_cnt   = 1'b1;
        e.cnt       = exp_cnt;
        sb.push_back(e);
        e.tag       = cyc + 1;
        e.chk_sel   = 1'b1;
        e.sel       = exp_sel;
        e.chk_stall = 1'b0;
        e.chk_cnt   = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pushAllZero(input string name);
        exp_t e;
        e.name      = name;
        e.tag       = cyc;
        e.chk_sel   = 1'b1;
        e.sel       = '0;
        e.chk_stall = 1'b1;
        e.stall     = 1'b0;
        e.chk_cnt   = 1'b1;
        e.cnt       = '0;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushAllZero("reset_init");

        // name, {src1,src0}, used, {rd2,rd1,rd0}, wr, load, flush, stall, sel(next), stall_cnt
        applyStimulus("ex_fwd_r5",     {5'd0, 5'd5},  2'b01, {5'd0, 5'd0, 5'd5},   3'b001, 3'b000, 1'b0, 1'b0, 4'h1, 16'd0);
        applyStimulus("ex_mem_r7",     {5'd7, 5'd0},  2'b10, {5'd0, 5'd7, 5'd7},   3'b011, 3'b000, 1'b0, 1'b0, 4'h4, 16'd0);
        applyStimulus("mem_only_r7",   {5'd7, 5'd0},  2'b10, {5'd0, 5'd7, 5'd7},   3'b010, 3'b000, 1'b0, 1'b0, 4'h8, 16'd0);
        applyStimulus("r0_no_fwd",     {5'd0, 5'd0},  2'b01, {5'd0, 5'd0, 5'd0},   3'b001, 3'b001, 1'b0, 1'b0, 4'h0, 16'd0);
        applyStimulus("unused_no_fwd", {5'd0, 5'd9},  2'b00, {5'd0, 5'd0, 5'd9},   3'b001, 3'b001, 1'b0, 1'b0, 4'h0, 16'd0);
        applyStimulus("wb_mem_both",   {5'd6, 5'd4},  2'b11, {5'd4, 5'd6, 5'd0},   3'b110, 3'b000, 1'b0, 1'b0, 4'hB, 16'd0);

        // Load-use on operand 1: two stall cycles, then forward from WB.
        applyStimulus("lu_stall1",     {5'd3, 5'd0},  2'b10, {5'd0, 5'd0, 5'd3},   3'b001, 3'b001, 1'b0, 1'b1, 4'h0, 16'd0);
        applyStimulus("lu_stall2",     {5'd3, 5'd0},  2'b10, {5'd0, 5'd3, 5'd0},   3'b010, 3'b010, 1'b0, 1'b1, 4'h0, 16'd1);
        applyStimulus("lu_after",      {5'd3, 5'd0},  2'b10, {5'd3, 5'd0, 5'd0},   3'b100, 3'b100, 1'b0, 1'b0, 4'hC, 16'd2);

        // Flush during the STALL state.
        applyStimulus("fl_hazard",     {5'd0, 5'd8},  2'b01, {5'd0, 5'd0, 5'd8},   3'b001, 3'b001, 1'b0, 1'b1, 4'h0, 16'd2);
        applyStimulus("fl_in_stall",   {5'd0, 5'd8},  2'b01, {5'd0, 5'd8, 5'd0},   3'b010, 3'b010, 1'b1, 1'b0, 4'h0, 16'd3);
        applyStimulus("fl_idle_after", {5'd0, 5'd8},  2'b01, {5'd8, 5'd0, 5'd0},   3'b100, 3'b100, 1'b0, 1'b0, 4'h3, 16'd3);

        // Flush in the cycle a hazard is first seen, then the same hazard unflushed.
        applyStimulus("fl_over_haz",   {5'd0, 5'd2},  2'b01, {5'd0, 5'd0, 5'd2},   3'b001, 3'b001, 1'b1, 1'b0, 4'h0, 16'd3);
        applyStimulus("haz_again1",    {5'd0, 5'd2},  2'b01, {5'd0, 5'd0, 5'd2},   3'b001, 3'b001, 1'b0, 1'b1, 4'h0, 16'd3);
        applyStimulus("haz_again2",    {5'd0, 5'd2},  2'b01, {5'd0, 5'd2, 5'd0},   3'b010, 3'b010, 1'b0, 1'b1, 4'h0, 16'd4);
        applyStimulus("haz_again_end", {5'd0, 5'd2},  2'b01, {5'd2, 5'd0, 5'd0},   3'b100, 3'b100, 1'b0, 1'b0, 4'h3, 16'd5);

        // EX load on operand 0 with a MEM match on operand 1: stall wins.
        applyStimulus("dual_stall1",   {5'd11, 5'd10}, 2'b11, {5'd0, 5'd11, 5'd10}, 3'b011, 3'b001, 1'b0, 1'b1, 4'h0, 16'd5);
        applyStimulus("dual_stall2",   {5'd11, 5'd10}, 2'b11, {5'd11, 5'd10, 5'd0}, 3'b110, 3'b010, 1'b0, 1'b1, 4'h0, 16'd6);
        applyStimulus("dual_after",    {5'd11, 5'd10}, 2'b11, {5'd10, 5'd0, 5'd0},  3'b100, 3'b100, 1'b0, 1'b0, 4'h3, 16'd7);

        applyStimulus("mem_load_fwd",  {5'd0, 5'd12}, 2'b01, {5'd0, 5'd12, 5'd0},  3'b010, 3'b010, 1'b0, 1'b0, 4'h2, 16'd7);
        applyStimulus("youngest_wins", {5'd13, 5'd0}, 2'b10, {5'd13, 5'd13, 5'd13}, 3'b111, 3'b000, 1'b0, 1'b0, 4'h4, 16'd7);

        // Held load-use keeps stalling every cycle; the 4-bit counter saturates.
        for (int j = 0; j < 12; j++) begin
            applyStimulus("sat_stall", {5'd0, 5'd14}, 2'b01, {5'd0, 5'd0, 5'd14}, 3'b001, 3'b001, 1'b0, 1'b1, 4'h0, 16'(7 + j));
        end
        applyStimulus("sat_quiet",     {5'd0, 5'd0},  2'b00, {5'd0, 5'd0, 5'd0},   3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'd19);

        // Mid-run asynchronous reset with a live select and a nonzero counter.
        applyStimulus("pre_reset",     {5'd0, 5'd5},  2'b01, {5'd0, 5'd0, 5'd5},   3'b001, 3'b000, 1'b0, 1'b0, 4'h1, 16'd19);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pushAllZero("reset_async");
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        id_src_addr = '0;
        id_src_used = '0;
        prod_rd     = '0;
        prod_wr     = '0;
        prod_load   = '0;
        applyStimulus("post_reset",    {5'd0, 5'd0},  2'b00, {5'd0, 5'd0, 5'd0},   3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'd0);

        repeat (3) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s unchecked: still queued at cycle %0d, required at %0d", e.name, cyc, e.tag);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
